// File: rtl/alu_regfile_wb_if.sv
// Operand/write-back bus between the ALU datapath and its register file.
// Master drives issue/ALU/ext-load; slave (alu_regfile_wb) drives operands and write-back.
interface alu_regfile_wb_if #(
    parameter int AW = 3,
    parameter int DW = 32
);
    logic          issue_valid;
    logic          issue_ready;
    logic [AW-1:0] issue_rs1;
    logic [AW-1:0] issue_rs2;
    logic [AW-1:0] issue_rd;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] alu_result;
    logic          alu_cout;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_data;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic          carry_flag;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd,
        output alu_result, alu_cout,
        output ext_we, ext_addr, ext_data,
        input  issue_ready, op_a, op_b, wb_valid, wb_addr, carry_flag
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd,
        input  alu_result, alu_cout,
        input  ext_we, ext_addr, ext_data,
        output issue_ready, op_a, op_b, wb_valid, wb_addr, carry_flag
    );
endinterface

// File: rtl/alu_regfile_wb.sv
// Register file, operand supply and one-cycle-latency write-back for the 32-bit ALU.
// Optional operand forwarding from the in-flight result: define ALU_RF_BYPASS_EN.
module alu_regfile_wb #(
    parameter int AW = 3,
    parameter int DW = 32
) (
    input logic             clk,
    input logic             rst,
    alu_regfile_wb_if.slave bus
);
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic {
        S_IDLE,
        S_PEND
    } pend_state_t;

    pend_state_t   state;
    pend_state_t   state_nx;
    logic [AW-1:0] pend_rd;
    logic          pend_valid;
    logic          accept;
    logic          ready;
    logic          carry_q;
    logic [DW-1:0] rf [DEPTH];
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;

    // Pending slot: an accepted op always writes back in the very next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = S_IDLE;
        pend_valid = (state == S_PEND);
        accept     = bus.issue_valid && ready;
        if (accept) begin
            state_nx = S_PEND;
        end
    end

    always_comb begin
        rd_a = (bus.issue_rs1 == '0) ? '0 : rf[bus.issue_rs1];
        rd_b = (bus.issue_rs2 == '0) ? '0 : rf[bus.issue_rs2];
`ifdef ALU_RF_BYPASS_EN
        ready = 1'b1;
        if (pend_valid && (pend_rd != '0) && (bus.issue_rs1 == pend_rd)) begin
            rd_a = bus.alu_result;
        end
        if (pend_valid && (pend_rd != '0) && (bus.issue_rs2 == pend_rd)) begin
            rd_b = bus.alu_result;
        end
`else
        ready = !(pend_valid && (pend_rd != '0) &&
                  ((bus.issue_rs1 == pend_rd) || (bus.issue_rs2 == pend_rd)));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_rd <= '0;
            carry_q <= 1'b0;
        end else if (accept) begin
            pend_rd <= bus.issue_rd;
            carry_q <= bus.alu_cout;
        end
    end

    // Write-back is issued after the external write so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rf[i[AW-1:0]] <= '0;
            end
        end else begin
            if (bus.ext_we && (bus.ext_addr != '0)) begin
                rf[bus.ext_addr] <= bus.ext_data;
            end
            if (pend_valid && (pend_rd != '0)) begin
                rf[pend_rd] <= bus.alu_result;
            end
        end
    end

    assign bus.issue_ready = ready;
    assign bus.op_a        = rd_a;
    assign bus.op_b        = rd_b;
    assign bus.wb_valid    = pend_valid;
    assign bus.wb_addr     = pend_rd;
    assign bus.carry_flag  = carry_q;

endmodule

// File: tb/tb_alu_regfile_wb.sv
// Self-checking bench for alu_regfile_wb with a behavioural ALU (add / NOT) and RF scoreboard.
module tb_alu_regfile_wb;
    localparam int AW = 3;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic alu_sel = 1'b1;   // 1: add, 0: NOT A
    always #5 clk = ~clk;

    alu_regfile_wb_if #(.AW(AW), .DW(DW)) bus ();
    alu_regfile_wb #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Behavioural ALU: carry combinational, result registered.
    logic [DW:0] sum_w;
    always_comb begin
        sum_w        = {1'b0, bus.op_a} + {1'b0, bus.op_b};
        bus.alu_cout = alu_sel ? sum_w[DW] : 1'b0;
    end
    always @(posedge clk) bus.alu_result <= alu_sel ? sum_w[DW-1:0] : ~bus.op_a;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] val;
        logic          cout;
    } exp_t;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          sel;
        logic [AW-1:0] rd;
        logic [DW-1:0] exp_res;
        logic          exp_cout;
    } vec_t;

    exp_t          q[$];
    logic [DW-1:0] mdl [8];
    logic          exp_carry = 1'b0;
    bit            mon_en = 1'b0;
    int            n_checks = 0;
    int            n_errors = 0;

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (a == '0) return '0;
`ifdef ALU_RF_BYPASS_EN
        if (q.size() > 0 && q[0].rd == a) return q[0].val;
`endif
        return mdl[a];
    endfunction

    function automatic logic exp_ready_f();
`ifdef ALU_RF_BYPASS_EN
        return 1'b1;
`else
        if (q.size() > 0 && q[0].rd != '0 &&
            (bus.issue_rs1 == q[0].rd || bus.issue_rs2 == q[0].rd)) return 1'b0;
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard update at each active edge: ext write, then retire, then new issue.
    always @(posedge clk) begin
        logic          acc;
        exp_t          e;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW:0]   s;
        if (rst) begin
            q.delete();
            exp_carry = 1'b0;
            foreach (mdl[i]) mdl[i] = '0;
        end else begin
            acc = bus.issue_valid && exp_ready_f();
            a   = model_rd(bus.issue_rs1);
            b   = model_rd(bus.issue_rs2);
            s   = {1'b0, a} + {1'b0, b};
            if (bus.ext_we && bus.ext_addr != '0) mdl[bus.ext_addr] = bus.ext_data;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.rd != '0) mdl[e.rd] = e.val;
            end
            if (acc) begin
                e.rd   = bus.issue_rd;
                e.val  = alu_sel ? s[DW-1:0] : ~a;
                e.cout = alu_sel ? s[DW] : 1'b0;
                q.push_back(e);
                exp_carry = e.cout;
            end
        end
    end

    // Per-cycle monitor, sampled away from the active edge.
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            chk("issue_ready", {31'b0, bus.issue_ready}, {31'b0, exp_ready_f()});
            chk("op_a", bus.op_a, model_rd(bus.issue_rs1));
            chk("op_b", bus.op_b, model_rd(bus.issue_rs2));
            chk("carry_flag", {31'b0, bus.carry_flag}, {31'b0, exp_carry});
            if (q.size() > 0) begin
                chk("wb_valid", {31'b0, bus.wb_valid}, 32'd1);
                chk("wb_addr", {29'b0, bus.wb_addr}, {29'b0, q[0].rd});
            end else begin
                chk("wb_idle", {31'b0, bus.wb_valid}, 32'd0);
            end
        end
    end

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.ext_we      = 1'b0;
    endtask

    task automatic nop();
        @(negedge clk);
        idle();
    endtask

    task automatic ext_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        idle();
        bus.ext_we   = 1'b1;
        bus.ext_addr = a;
        bus.ext_data = d;
    endtask

    task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic sel);
        @(negedge clk);
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_rs1   = rs1;
        bus.issue_rs2   = rs2;
        bus.issue_rd    = rd;
        alu_sel         = sel;
    endtask

    task automatic peek(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        @(negedge clk);
        idle();
        bus.issue_rs1 = rs1;
        bus.issue_rs2 = rs2;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{32'd5,        32'd7,        1'b1, 3'd3, 32'd12,       1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'd1,        1'b1, 3'd4, 32'd0,        1'b1};
        vecs[2] = '{32'd1,        32'd1,        1'b1, 3'd5, 32'd2,        1'b0};
        vecs[3] = '{32'h0F0F0F0F, 32'd9,        1'b0, 3'd6, 32'hF0F0F0F0, 1'b0};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b1, 3'd7, 32'd0,        1'b1};
        vecs[5] = '{32'h12345678, 32'h11111111, 1'b1, 3'd3, 32'h23456789, 1'b0};

        bus.issue_valid = 1'b0;
        bus.issue_rs1   = '0;
        bus.issue_rs2   = '0;
        bus.issue_rd    = '0;
        bus.ext_we      = 1'b0;
        bus.ext_addr    = '0;
        bus.ext_data    = '0;

        // Reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("rst_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
        chk("rst_wb_addr", {29'b0, bus.wb_addr}, 32'd0);
        chk("rst_carry", {31'b0, bus.carry_flag}, 32'd0);
        chk("rst_ready", {31'b0, bus.issue_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            peek(i[AW-1:0], i[AW-1:0]);
            chk("rst_op_a", bus.op_a, 32'd0);
            chk("rst_op_b", bus.op_b, 32'd0);
        end

        // Table-driven ALU write-back
        for (int i = 0; i < 6; i++) begin
            ext_load(3'd1, vecs[i].a);
            ext_load(3'd2, vecs[i].b);
            issue(3'd1, 3'd2, vecs[i].rd, vecs[i].sel);
            nop();
            peek(vecs[i].rd, 3'd0);
            chk("vec_result", bus.op_a, vecs[i].exp_res);
            chk("vec_carry", {31'b0, bus.carry_flag}, {31'b0, vecs[i].exp_cout});
        end

        // Back-to-back issues, no dependency
        issue(3'd1, 3'd2, 3'd6, 1'b1);
        issue(3'd2, 3'd1, 3'd7, 1'b0);
        nop();
        peek(3'd6, 3'd7);
        chk("b2b_r6", bus.op_a, 32'h23456789);
        chk("b2b_r7", bus.op_b, ~32'h11111111);

        // Hazard on the in-flight destination
        ext_load(3'd1, 32'd5);
        ext_load(3'd2, 32'd7);
        issue(3'd1, 3'd2, 3'd3, 1'b1);
        issue(3'd3, 3'd2, 3'd5, 1'b1);
        #1;
`ifdef ALU_RF_BYPASS_EN
        chk("bypass_ready", {31'b0, bus.issue_ready}, 32'd1);
        chk("bypass_op_a", bus.op_a, 32'd12);
`else
        chk("hazard_stall", {31'b0, bus.issue_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("stall_release", {31'b0, bus.issue_ready}, 32'd1);
        chk("stall_op_a", bus.op_a, 32'd12);
`endif
        nop();
        peek(3'd5, 3'd0);
        chk("hazard_result", bus.op_a, 32'd19);

        // Write-back to R0
        issue(3'd1, 3'd2, 3'd0, 1'b1);
        nop();
        #1;
        chk("r0_wb_valid", {31'b0, bus.wb_valid}, 32'd1);
        chk("r0_wb_addr", {29'b0, bus.wb_addr}, 32'd0);
        peek(3'd0, 3'd0);
        chk("r0_reads_zero", bus.op_a, 32'd0);

        // Same-address collision: write-back wins
        ext_load(3'd1, 32'd20);
        ext_load(3'd2, 32'd22);
        issue(3'd1, 3'd2, 3'd3, 1'b1);
        ext_load(3'd3, 32'hDEADBEEF);
        peek(3'd3, 3'd0);
        chk("collide_wb_wins", bus.op_a, 32'd42);

        // Different addresses: both commit
        issue(3'd1, 3'd2, 3'd4, 1'b1);
        ext_load(3'd6, 32'h55);
        peek(3'd4, 3'd6);
        chk("dual_wb", bus.op_a, 32'd42);
        chk("dual_ext", bus.op_b, 32'h55);

        // Reset during the write-back cycle
        ext_load(3'd1, 32'd100);
        issue(3'd1, 3'd2, 3'd3, 1'b1);
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
        chk("midrst_carry", {31'b0, bus.carry_flag}, 32'd0);
        peek(3'd3, 3'd1);
        chk("midrst_r3", bus.op_a, 32'd0);
        chk("midrst_r1", bus.op_b, 32'd0);

        nop();
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
